// File: rtl/phase_seq_pkg.sv
// rtl/phase_seq_pkg.sv - shared state encoding and default constants for the phase sequencer
package phase_seq_pkg;

    localparam int DEF_ITER_W          = 16;
    localparam int DEF_CORE_RST_CYCLES = 2;
    localparam int DEF_VXV_RST_CYCLES  = 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CORE_RST = 3'd1,
        ST_MXV_RUN  = 3'd2,
        ST_VXV_RST  = 3'd3,
        ST_VXV_RUN  = 3'd4,
        ST_DONE     = 3'd5
`ifdef PHASE_SEQ_TIMEOUT_EN
        , ST_ERR    = 3'd6
`endif
    } state_t;

endpackage

// File: rtl/phase_seq_timer.sv
// rtl/phase_seq_timer.sv - loadable down-counter with zero flag for reset hold timing
module phase_seq_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - core/mXv/vXv reset phase sequencer; PHASE_SEQ_TIMEOUT_EN adds a per-phase watchdog
module phase_sequencer
    import phase_seq_pkg::*;
#(
    parameter int CORE_RST_CYCLES = DEF_CORE_RST_CYCLES,
    parameter int VXV_RST_CYCLES  = DEF_VXV_RST_CYCLES,
    parameter int MAX_ITER        = 1024,
    parameter int ITER_W          = DEF_ITER_W,
    parameter int TIMEOUT_CYCLES  = 65535
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              reset_cluster,
    input  logic              halt,
    output logic              core_reset,
    output logic              reset_mXv1,
    output logic              reset_vXv1,
    output logic              busy,
    output logic              done,
    output logic              hit_limit,
    output logic [ITER_W-1:0] iter_count,
    output logic              err
);

    localparam int TMR_MAX = (CORE_RST_CYCLES > VXV_RST_CYCLES) ? CORE_RST_CYCLES : VXV_RST_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam logic [TMR_W-1:0] CORE_VAL = TMR_W'(CORE_RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] VXV_VAL  = TMR_W'(VXV_RST_CYCLES - 1);
    localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);

    state_t              state_q, state_d;
    logic [ITER_W-1:0]   iter_q, iter_d, iter_inc;
    logic                hit_limit_q, hit_limit_d;
    logic                rc_q, rc_rise;
    logic                core_reset_q, core_reset_d;
    logic                mxv_q, mxv_d;
    logic                vxv_q, vxv_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                tmr_load, tmr_zero;
    logic [TMR_W-1:0]    tmr_val;

`ifdef PHASE_SEQ_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0]     wd_q, wd_d;
    logic                err_q, err_d;
`endif

    phase_seq_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // The registered copy makes a held-high reset_cluster a single event.
    assign rc_rise  = reset_cluster & ~rc_q;
    assign iter_inc = (iter_q == '1) ? iter_q : iter_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        iter_d      = iter_q;
        hit_limit_d = hit_limit_q;
        tmr_load    = 1'b0;
        tmr_val     = '0;
        case (state_q)
            ST_CORE_RST: begin
                if (tmr_zero) state_d = ST_MXV_RUN;
            end
            ST_MXV_RUN: begin
                if (halt) begin
                    state_d = ST_DONE;
                end else if (rc_rise) begin
                    state_d  = ST_VXV_RST;
                    tmr_load = 1'b1;
                    tmr_val  = VXV_VAL;
                end
            end
            ST_VXV_RST: begin
                if (halt) state_d = ST_DONE;
                else if (tmr_zero) state_d = ST_VXV_RUN;
            end
            ST_VXV_RUN: begin
                if (halt) begin
                    state_d = ST_DONE;
                end else if (rc_rise) begin
                    iter_d = iter_inc;
                    if (iter_inc == ITER_LIMIT) begin
                        state_d     = ST_DONE;
                        hit_limit_d = 1'b1;
                    end else begin
                        state_d = ST_MXV_RUN;
                    end
                end
            end
            default: begin
                // IDLE, DONE and ERR all restart the same way.
                if (start) begin
                    state_d     = ST_CORE_RST;
                    iter_d      = '0;
                    hit_limit_d = 1'b0;
                    tmr_load    = 1'b1;
                    tmr_val     = CORE_VAL;
                end
            end
        endcase

`ifdef PHASE_SEQ_TIMEOUT_EN
        // Staying put in a run state means no phase event occurred this cycle.
        wd_d = '0;
        if (state_d == state_q && (state_q == ST_MXV_RUN || state_q == ST_VXV_RUN)) begin
            if (wd_q == WD_LAST) state_d = ST_ERR;
            else wd_d = wd_q + 1'b1;
        end
`endif
    end

    always_comb begin
        core_reset_d = 1'b1;
        mxv_d        = 1'b0;
        vxv_d        = 1'b1;
        busy_d       = 1'b0;
        done_d       = 1'b0;
`ifdef PHASE_SEQ_TIMEOUT_EN
        err_d        = (state_d == ST_ERR);
`endif
        case (state_d)
            ST_CORE_RST: busy_d = 1'b1;
            ST_MXV_RUN: begin
                core_reset_d = 1'b0;
                mxv_d        = 1'b1;
                vxv_d        = 1'b0;
                busy_d       = 1'b1;
            end
            ST_VXV_RST: begin
                core_reset_d = 1'b0;
                busy_d       = 1'b1;
            end
            ST_VXV_RUN: begin
                core_reset_d = 1'b0;
                vxv_d        = 1'b0;
                busy_d       = 1'b1;
            end
            ST_DONE: begin
                core_reset_d = 1'b0;
                done_d       = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            iter_q       <= '0;
            hit_limit_q  <= 1'b0;
            rc_q         <= 1'b0;
            core_reset_q <= 1'b1;
            mxv_q        <= 1'b0;
            vxv_q        <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef PHASE_SEQ_TIMEOUT_EN
            wd_q         <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            iter_q       <= iter_d;
            hit_limit_q  <= hit_limit_d;
            rc_q         <= reset_cluster;
            core_reset_q <= core_reset_d;
            mxv_q        <= mxv_d;
            vxv_q        <= vxv_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef PHASE_SEQ_TIMEOUT_EN
            wd_q         <= wd_d;
            err_q        <= err_d;
`endif
        end
    end

    assign core_reset = core_reset_q;
    assign reset_mXv1 = mxv_q;
    assign reset_vXv1 = vxv_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign hit_limit  = hit_limit_q;
    assign iter_count = iter_q;
`ifdef PHASE_SEQ_TIMEOUT_EN
    assign err        = err_q;
`else
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_phase_sequencer.sv
// tb/tb_phase_sequencer.sv - scoreboard bench for phase_sequencer (watchdog case under PHASE_SEQ_TIMEOUT_EN)
module tb_phase_sequencer;

    localparam int ITER_W = 16;
    localparam int IDLE = 0, CRST = 1, MXV = 2, VRST = 3, VRUN = 4, DONE = 5, ERR = 6;

    logic              clk = 1'b0;
    logic              reset, start, reset_cluster, halt;
    logic              core_reset, reset_mXv1, reset_vXv1, busy, done, hit_limit, err;
    logic [ITER_W-1:0] iter_count;

    typedef struct {
        logic [22:0] v;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    phase_sequencer #(
        .CORE_RST_CYCLES (2),
        .VXV_RST_CYCLES  (2),
        .MAX_ITER        (3),
        .ITER_W          (ITER_W),
        .TIMEOUT_CYCLES  (100)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .reset_cluster (reset_cluster),
        .halt          (halt),
        .core_reset    (core_reset),
        .reset_mXv1    (reset_mXv1),
        .reset_vXv1    (reset_vXv1),
        .busy          (busy),
        .done          (done),
        .hit_limit     (hit_limit),
        .iter_count    (iter_count),
        .err           (err)
    );

    // Flags: {core_reset, reset_mXv1, reset_vXv1, busy, done, hit_limit, err}
    function automatic logic [22:0] ev(input int st, input int it, input logic hl);
        logic [6:0] f;
        case (st)
            IDLE:    f = 7'b1010000;
            CRST:    f = 7'b1011000;
            MXV:     f = 7'b0101000;
            VRST:    f = 7'b0011000;
            VRUN:    f = 7'b0001000;
            DONE:    f = 7'b0010100;
            default: f = 7'b1010001;
        endcase
        f[1] = hl;
        return {f, 16'(it)};
    endfunction

    function automatic logic [22:0] act();
        return {core_reset, reset_mXv1, reset_vXv1, busy, done, hit_limit, err, iter_count};
    endfunction

    task automatic cmp(input logic [22:0] got, input logic [22:0] want, input string nm);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            cmp(act(), e.v, e.nm);
        end
    end

    task automatic cyc(input logic s, input logic rc, input logic h,
                       input int st, input int it, input logic hl, input string nm);
        exp_t e;
        start         = s;
        reset_cluster = rc;
        halt          = h;
        e.v  = ev(st, it, hl);
        e.nm = nm;
        sb.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; reset_cluster = 1'b0; halt = 1'b0;
        @(negedge clk);
        cyc(0, 0, 0, IDLE, 0, 0, "reset_state");
        reset = 1'b1;
        cyc(0, 0, 0, IDLE, 0, 0, "idle");
        cyc(0, 0, 1, IDLE, 0, 0, "halt_idle_ignored");

        cyc(1, 0, 0, CRST, 0, 0, "core_rst_1");
        cyc(0, 0, 0, CRST, 0, 0, "core_rst_2");
        cyc(0, 0, 0, MXV,  0, 0, "mxv_entry");

        cyc(0, 1, 0, VRST, 0, 0, "vxv_rst_1");
        cyc(0, 1, 0, VRST, 0, 0, "vxv_rst_2");
        cyc(0, 1, 0, VRUN, 0, 0, "vxv_run_entry");
        cyc(0, 1, 0, VRUN, 0, 0, "level_no_event_1");
        cyc(0, 1, 0, VRUN, 0, 0, "level_no_event_2");
        cyc(0, 0, 0, VRUN, 0, 0, "rc_low");

        cyc(0, 1, 0, MXV,  1, 0, "iter_1");
        cyc(1, 0, 0, MXV,  1, 0, "start_ignored");
        cyc(0, 1, 0, VRST, 1, 0, "iter_1_vrst");
        cyc(0, 0, 0, VRST, 1, 0, "iter_1_vrst_2");
        cyc(0, 0, 0, VRUN, 1, 0, "iter_1_vrun");
        cyc(0, 1, 0, MXV,  2, 0, "iter_2");
        cyc(0, 0, 0, MXV,  2, 0, "iter_2_mxv");
        cyc(0, 1, 0, VRST, 2, 0, "iter_2_vrst");
        cyc(0, 0, 0, VRST, 2, 0, "iter_2_vrst_2");
        cyc(0, 0, 0, VRUN, 2, 0, "iter_2_vrun");
        cyc(0, 1, 0, DONE, 3, 1, "hit_limit");
        cyc(0, 0, 0, DONE, 3, 1, "done_sticky");
        cyc(0, 1, 1, DONE, 3, 1, "done_holds");
        cyc(1, 0, 0, CRST, 0, 0, "restart_clears");

        cyc(0, 0, 1, CRST, 0, 0, "halt_core_rst_ignored");
        cyc(0, 0, 0, MXV,  0, 0, "mxv_after_halt_ignore");
        cyc(0, 1, 0, VRST, 0, 0, "halt_test_vrst");
        cyc(0, 0, 0, VRST, 0, 0, "halt_test_vrst_2");
        cyc(0, 0, 0, VRUN, 0, 0, "halt_test_vrun");
        cyc(0, 1, 1, DONE, 0, 0, "halt_beats_edge");
        cyc(0, 0, 0, DONE, 0, 0, "halt_done_hold");

        cyc(1, 0, 0, CRST, 0, 0, "rerun_crst");
        cyc(0, 0, 0, CRST, 0, 0, "rerun_crst_2");
        cyc(0, 0, 0, MXV,  0, 0, "rerun_mxv");
        cyc(0, 1, 0, VRST, 0, 0, "rerun_vrst");
        cyc(0, 0, 0, VRST, 0, 0, "rerun_vrst_2");
        cyc(0, 0, 0, VRUN, 0, 0, "rerun_vrun");
        cyc(0, 1, 0, MXV,  1, 0, "rerun_iter_1");
        cyc(0, 0, 0, MXV,  1, 0, "rerun_mxv_2");
        cyc(0, 1, 0, VRST, 1, 0, "rerun_vrst_mid");
        reset = 1'b0;
        #1;
        cmp(act(), ev(IDLE, 0, 0), "async_reset");
        @(negedge clk);
        cyc(0, 0, 0, IDLE, 0, 0, "reset_held");
        reset = 1'b1;
        cyc(0, 0, 0, IDLE, 0, 0, "after_release");
        cyc(0, 1, 0, IDLE, 0, 0, "rc_idle_ignored");
        cyc(0, 0, 0, IDLE, 0, 0, "idle_stays");

`ifdef PHASE_SEQ_TIMEOUT_EN
        cyc(1, 0, 0, CRST, 0, 0, "wd_crst");
        cyc(0, 0, 0, CRST, 0, 0, "wd_crst_2");
        cyc(0, 0, 0, MXV,  0, 0, "wd_mxv");
        for (int i = 0; i < 99; i++) cyc(0, 0, 0, MXV, 0, 0, "wd_wait");
        cyc(0, 0, 0, ERR,  0, 0, "wd_err");
        cyc(0, 0, 0, ERR,  0, 0, "wd_err_hold");
        cyc(1, 0, 0, CRST, 0, 0, "wd_err_restart");
`endif

        repeat (2) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
